vector_result_bank: RTL and testbench

// - Parametrised successor of the multiply result bank in DECODE. It assembles SLOTS write beats of

---
 rtl/vector_result_bank.sv | 135 +++++++++++++
 tb/tb_vector_result_bank.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_result_bank.sv
// vector_result_bank
//
// Ping-pong result bank between the vector multiply lanes and writeback.
// A producer delivers SLOTS beats of LANES words each. Those beats are
// assembled into one vector of LANES*SLOTS words. Two buffers let the
// producer fill one vector while the consumer still holds the other.
// Completed vectors leave in the order they were completed, so the bank
// behaves as a FIFO of depth 2.
//
// Optional feature macro: VRB_PARTIAL_EN
//   When it is defined, an accepted beat with in_last=1 closes the vector
//   early. Every slot above the current one is zero-filled in that same
//   cycle. When it is undefined, in_last is ignored and every vector is
//   exactly SLOTS beats long.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   producer beat valid
//   in_ready   bank can accept a beat (registered, no path from out_ready)
//   in_data    one beat, lane i at [i*DATA_W +: DATA_W]
//   in_last    early end-of-vector (VRB_PARTIAL_EN builds only)
//   out_valid  a complete vector is presented
//   out_ready  consumer accepts the presented vector
//   out_data   vector, word (s*LANES+i) = lane i of beat s
//   occupancy  number of full buffers, 0..2

module vector_result_bank #(
   parameter int DATA_W = 32,
   parameter int LANES  = 4,
   parameter int SLOTS  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES*DATA_W-1:0]       in_data,
   input  logic                          in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES*SLOTS*DATA_W-1:0] out_data,
   output logic [1:0]                    occupancy
);

   localparam int BEAT_W = LANES * DATA_W;
   localparam int VEC_W  = BEAT_W * SLOTS;
   localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

   logic [VEC_W-1:0]  buf_mem [2];
   logic [1:0]        full;
   logic [1:0]        full_next;
   logic              wb;
   logic              rb;
   logic [SLOT_W-1:0] slot;

   logic              in_fire;
   logic              out_fire;
   logic              close_vec;
   logic [VEC_W-1:0]  wr_vec;

   assign in_ready  = ~full[wb];
   assign out_valid = full[rb];
   assign out_data  = buf_mem[rb];
   assign occupancy = {1'b0, full[0]} + {1'b0, full[1]};

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

`ifdef VRB_PARTIAL_EN
   assign close_vec = (slot == LAST_SLOT) | in_last;
`else
   assign close_vec = (slot == LAST_SLOT);

   logic unused_in_last;
   assign unused_in_last = in_last;
`endif

   // Next contents of the write buffer. The current beat lands in its slot.
   // On an early close, the slots above it are cleared, so stale words from an
   // earlier vector in this buffer never leak into the output.
   always_comb begin
      wr_vec = buf_mem[wb];
      for (int s = 0; s < SLOTS; s++) begin
         if (s == int'(slot)) begin
            wr_vec[s*BEAT_W +: BEAT_W] = in_data;
         end
`ifdef VRB_PARTIAL_EN
         else if (in_last && (s > int'(slot))) begin
            wr_vec[s*BEAT_W +: BEAT_W] = '0;
         end
`endif
      end
   end

   // A completion and a pop in the same cycle always address different
   // buffers. A buffer being written is never full, and a buffer being read
   // always is. Both updates can therefore be merged without a conflict.
   always_comb begin
      full_next = full;
      if (in_fire && close_vec) begin
         full_next[wb] = 1'b1;
      end
      if (out_fire) begin
         full_next[rb] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         full       <= '0;
         wb         <= 1'b0;
         rb         <= 1'b0;
         slot       <= '0;
      end else begin
         full <= full_next;
         if (in_fire) begin
            buf_mem[wb] <= wr_vec;
            if (close_vec) begin
               wb   <= ~wb;
               slot <= '0;
            end else begin
               slot <= slot + SLOT_W'(1);
            end
         end
         // Popping only moves the read pointer; buffer contents are kept.
         if (out_fire) begin
            rb <= ~rb;
         end
      end
   end

endmodule

// File: tb/tb_vector_result_bank.sv
// Testbench for vector_result_bank (DATA_W=32, LANES=4, SLOTS=2).
// The reference model is a queue of expected vectors. It is built from the
// words of the accepted beats and padded with zeros when a vector closes early.
// The monitor checks the DUT against the head of the queue on every cycle.

module tb_vector_result_bank;

   localparam int DATA_W = 32;
   localparam int LANES  = 4;
   localparam int SLOTS  = 2;
   localparam int BEAT_W = LANES * DATA_W;
   localparam int VEC_W  = BEAT_W * SLOTS;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [BEAT_W-1:0] in_data = '0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [VEC_W-1:0]  out_data;
   logic [1:0]        occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [VEC_W-1:0]  exp_q [$];
   logic [DATA_W-1:0] words [$];

   vector_result_bank #(.DATA_W(DATA_W), .LANES(LANES), .SLOTS(SLOTS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Beat whose lanes hold start, start+1, ... (lane 0 = start).
   function automatic logic [BEAT_W-1:0] beat_of(input int start);
      logic [BEAT_W-1:0] b;
      b = '0;
      for (int i = 0; i < LANES; i++) b[i*DATA_W +: DATA_W] = DATA_W'(start + i);
      return b;
   endfunction

   // Vector whose first n words are start, start+1, ...; the remaining words are zero.
   function automatic logic [VEC_W-1:0] seq_vec(input int start, input int n);
      logic [VEC_W-1:0] v;
      v = '0;
      for (int k = 0; k < n; k++) v[k*DATA_W +: DATA_W] = DATA_W'(start + k);
      return v;
   endfunction

   task automatic model_beat(input logic [BEAT_W-1:0] d, input logic l);
      logic             done;
      logic [VEC_W-1:0] v;
      logic             unused_l;
      for (int i = 0; i < LANES; i++) words.push_back(d[i*DATA_W +: DATA_W]);
      done = (words.size() == LANES * SLOTS);
`ifdef VRB_PARTIAL_EN
      if (l) done = 1'b1;
`endif
      unused_l = l;
      if (done) begin
         v = '0;
         for (int k = 0; k < words.size(); k++) v[k*DATA_W +: DATA_W] = words[k];
         exp_q.push_back(v);
         words.delete();
      end
   endtask

   // Advance one clock. The beat decision is taken before the edge, and the
   // model is updated just after it.
   task automatic step();
      logic              fi;
      logic [BEAT_W-1:0] d;
      logic              l;
      @(negedge clk);
      fi = in_valid && in_ready && !rst;
      d  = in_data;
      l  = in_last;
      @(posedge clk);
      #1;
      if (rst) begin
         exp_q.delete();
         words.delete();
      end else if (fi) begin
         model_beat(d, l);
      end
   endtask

   // Monitor: the DUT state must agree with the queue. The head is popped on an out fire.
   always @(negedge clk) begin
      if (!rst) begin
         check("occupancy", VEC_W'(occupancy), VEC_W'(exp_q.size()));
         check("out_valid", VEC_W'(out_valid), VEC_W'(exp_q.size() != 0));
         check("in_ready",  VEC_W'(in_ready),  VEC_W'(exp_q.size() < 2));
         if (out_valid && exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
         if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
   end

   task automatic drain();
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8 && exp_q.size() > 0; i++) step();
      out_ready = 1'b0;
      check("drain_occ", VEC_W'(occupancy), '0);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_in_ready",  VEC_W'(in_ready),  VEC_W'(1));
      check("rst_out_valid", VEC_W'(out_valid), '0);
      check("rst_occupancy", VEC_W'(occupancy), '0);
      check("rst_out_data",  out_data,          '0);

      // Basic vector
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = beat_of(1);
      step();
      in_data   = beat_of(5);
      step();
      in_valid  = 1'b0;
      check("basic_valid", VEC_W'(out_valid), VEC_W'(1));
      check("basic_data",  out_data, seq_vec(1, 8));
      check("basic_occ",   VEC_W'(occupancy), VEC_W'(1));

      // Backpressure: second vector, then a stalled fifth beat
      in_valid = 1'b1;
      in_data  = beat_of(9);
      step();
      in_data  = beat_of(13);
      step();
      check("bp_in_ready", VEC_W'(in_ready),  '0);
      check("bp_occ",      VEC_W'(occupancy), VEC_W'(2));
      in_data  = beat_of(99);
      step();
      in_valid = 1'b0;
      check("bp_stall_occ", VEC_W'(occupancy), VEC_W'(2));
      check("bp_stall_data", out_data, seq_vec(1, 8));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp_pop_ready", VEC_W'(in_ready),  VEC_W'(1));
      check("bp_pop_data",  out_data, seq_vec(9, 8));
      check("bp_pop_occ",   VEC_W'(occupancy), VEC_W'(1));

      // Simultaneous completion of C and pop of B
      in_valid  = 1'b1;
      in_data   = beat_of(17);
      step();
      in_data   = beat_of(21);
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("sim_occ",  VEC_W'(occupancy), VEC_W'(1));
      check("sim_data", out_data, seq_vec(17, 8));
      drain();

      // Mid-vector reset
      in_valid = 1'b1;
      in_data  = beat_of(200);
      step();
      in_valid = 1'b0;
      rst      = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = beat_of(31);
      step();
      check("mvr_no_early", VEC_W'(out_valid), '0);
      in_data  = beat_of(35);
      step();
      in_valid = 1'b0;
      check("mvr_valid", VEC_W'(out_valid), VEC_W'(1));
      check("mvr_data",  out_data, seq_vec(31, 8));
      drain();

      // Early close through in_last
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = beat_of(1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
`ifdef VRB_PARTIAL_EN
      check("part_valid", VEC_W'(out_valid), VEC_W'(1));
      check("part_data",  out_data, seq_vec(1, 4));
`else
      check("part_valid", VEC_W'(out_valid), '0);
      check("part_occ",   VEC_W'(occupancy), '0);
      in_valid = 1'b1;
      in_data  = beat_of(5);
      step();
      in_valid = 1'b0;
      check("part_second_valid", VEC_W'(out_valid), VEC_W'(1));
      check("part_second_data",  out_data, seq_vec(1, 8));
`endif
      drain();

      // Random traffic with a reset in the middle
      for (int c = 0; c < 800; c++) begin
         if (c == 400) begin
            in_valid = 1'b0;
            rst      = 1'b1;
            step();
            rst      = 1'b0;
         end
         in_valid  = ($urandom_range(0, 3) != 0);
         in_last   = ($urandom_range(0, 3) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
         for (int i = 0; i < LANES; i++) in_data[i*DATA_W +: DATA_W] = $urandom;
         step();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
